// File: rtl/vme_iack_cycle_pkg.sv
// Shared types and encodings for the VME interrupt-acknowledge bridge.
package vme_iack_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    ACK,
    FAULT,
    RELEASE
  } state_t;

  localparam logic       ACTIVE     = 1'b0;
  localparam logic       INACTIVE   = 1'b1;
  localparam logic [1:0] DSACK_BYTE = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;
  localparam int         CNT_W      = 8;

endpackage

// File: rtl/vme_iack_cycle_sync2.sv
// Two-flop synchroniser for an active-low asynchronous VME response line.
module sync2
  import vme_iack_cycle_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= INACTIVE;
      q    <= INACTIVE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vme_iack_cycle.sv
// Bridges a CPU interrupt-acknowledge cycle onto the VME bus and returns the status/ID vector.
// Optional IACK_TIMEOUT_AVEC_EN: a timeout terminates with autovector instead of bus error.
module vme_iack_cycle
  import vme_iack_cycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iack_req,
  input  logic       cpu_as,
  input  logic [2:0] cpu_level,
  output logic [2:0] vme_level,
  output logic       vme_iack_n,
  output logic       vme_as_n,
  output logic       vme_ds0_n,
  input  logic       vme_dtack_n,
  input  logic       vme_berr_n,
  input  logic [7:0] vme_data,
  output logic [7:0] vector,
  output logic       vector_oe,
  output logic [1:0] cpu_dsack_n,
  output logic       cpu_berr_n,
  output logic       cpu_avec_n
);

  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] setup_cnt;
  logic             dtack_s;
  logic             berr_s;
  logic             timeout;

  sync2 dtack_sync (.clk(clk), .reset_n(reset_n), .d(vme_dtack_n), .q(dtack_s));
  sync2 berr_sync  (.clk(clk), .reset_n(reset_n), .d(vme_berr_n),  .q(berr_s));

  assign timeout = (to_cnt == TO_LAST);

`ifdef IACK_TIMEOUT_AVEC_EN
  logic avec_r;
  assign cpu_avec_n = avec_r;
`else
  assign cpu_avec_n = INACTIVE;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      vme_level   <= '0;
      vme_iack_n  <= INACTIVE;
      vme_as_n    <= INACTIVE;
      vme_ds0_n   <= INACTIVE;
      vector      <= '0;
      vector_oe   <= 1'b0;
      cpu_dsack_n <= DSACK_NONE;
      cpu_berr_n  <= INACTIVE;
      to_cnt      <= '0;
      setup_cnt   <= '0;
`ifdef IACK_TIMEOUT_AVEC_EN
      avec_r      <= INACTIVE;
`endif
    end else if (cpu_as == INACTIVE && state inside {SETUP, STROBE, WAIT, ACK, FAULT}) begin
      // CPU ended its cycle: drop every strobe and termination together.
      state       <= RELEASE;
      vme_iack_n  <= INACTIVE;
      vme_as_n    <= INACTIVE;
      vme_ds0_n   <= INACTIVE;
      vector_oe   <= 1'b0;
      cpu_dsack_n <= DSACK_NONE;
      cpu_berr_n  <= INACTIVE;
`ifdef IACK_TIMEOUT_AVEC_EN
      avec_r      <= INACTIVE;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iack_req && cpu_as == ACTIVE) begin
            state      <= SETUP;
            vme_level  <= cpu_level;
            vme_iack_n <= ACTIVE;
            setup_cnt  <= '0;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            vme_as_n <= ACTIVE;
            state    <= STROBE;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        STROBE: begin
          vme_ds0_n <= ACTIVE;
          to_cnt    <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // DTACK has priority over BERR when both arrive on the same clock.
          if (dtack_s == ACTIVE) begin
            vector      <= vme_data;
            vector_oe   <= 1'b1;
            cpu_dsack_n <= DSACK_BYTE;
            state       <= ACK;
          end else if (berr_s == ACTIVE) begin
            cpu_berr_n <= ACTIVE;
            state      <= FAULT;
          end else if (timeout) begin
`ifdef IACK_TIMEOUT_AVEC_EN
            avec_r     <= ACTIVE;
`else
            cpu_berr_n <= ACTIVE;
`endif
            state      <= FAULT;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ACK, FAULT: begin
          state <= state;
        end
        RELEASE: begin
          // The slave must release its response before another cycle may start.
          if (dtack_s == INACTIVE && berr_s == INACTIVE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_iack_cycle.sv
// Scoreboard bench for vme_iack_cycle: directed IACK cycles, expected terminations queued and matched by a monitor.
module tb_vme_iack_cycle;

  localparam int TO     = 16;
  localparam int K_ACK  = 0;
  localparam int K_BERR = 1;
  localparam int K_AVEC = 2;
  localparam int K_REL  = 3;
`ifdef IACK_TIMEOUT_AVEC_EN
  localparam int K_TO = K_AVEC;
`else
  localparam int K_TO = K_BERR;
`endif

  typedef struct {
    int         kind;
    logic [2:0] lvl;
    logic [7:0] vec;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ds_cyc = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       iack_req;
  logic       cpu_as;
  logic [2:0] cpu_level;
  logic [2:0] vme_level;
  logic       vme_iack_n;
  logic       vme_as_n;
  logic       vme_ds0_n;
  logic       vme_dtack_n;
  logic       vme_berr_n;
  logic [7:0] vme_data;
  logic [7:0] vector;
  logic       vector_oe;
  logic [1:0] cpu_dsack_n;
  logic       cpu_berr_n;
  logic       cpu_avec_n;

  vme_iack_cycle #(.TIMEOUT_CYCLES(TO), .SETUP_CYCLES(1)) dut (
    .clk(clk), .reset_n(reset_n), .iack_req(iack_req), .cpu_as(cpu_as),
    .cpu_level(cpu_level), .vme_level(vme_level), .vme_iack_n(vme_iack_n),
    .vme_as_n(vme_as_n), .vme_ds0_n(vme_ds0_n), .vme_dtack_n(vme_dtack_n),
    .vme_berr_n(vme_berr_n), .vme_data(vme_data), .vector(vector),
    .vector_oe(vector_oe), .cpu_dsack_n(cpu_dsack_n), .cpu_berr_n(cpu_berr_n),
    .cpu_avec_n(cpu_avec_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic push(input int kind, input logic [2:0] lvl, input logic [7:0] vec, input int lat);
    exp_q.push_back(exp_t'{kind, lvl, vec, lat});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle(input logic [2:0] lvl);
    tick();
    cpu_level = lvl;
    iack_req  = 1'b1;
    cpu_as    = 1'b0;
  endtask

  task automatic wait_ds(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vme_ds0_n === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("ds_wait", ok, 1);
  endtask

  // Monitor: every termination onset and every IACK release is matched against the queue.
  logic prev_term = 1'b0;
  logic prev_iack = 1'b1;
  logic prev_ds   = 1'b1;

  always @(negedge clk) begin : monitor
    logic term;
    int   akind;
    exp_t e;
    term = (cpu_dsack_n != 2'b11) || !cpu_berr_n || !cpu_avec_n;
    if (reset_n) begin
      if (prev_ds && !vme_ds0_n) ds_cyc = cyc;
      if (term && !prev_term) begin
        akind = (cpu_dsack_n != 2'b11) ? K_ACK : (!cpu_berr_n ? K_BERR : K_AVEC);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_term: got kind %0d, required no termination", akind);
        end else begin
          e = exp_q.pop_front();
          check("term_kind", akind, e.kind);
          check("term_level", vme_level, e.lvl);
          if (e.lat >= 0) check("term_latency", cyc - ds_cyc, e.lat);
          if (akind == K_ACK) begin
            check("vector", vector, e.vec);
            check("vector_oe", vector_oe, 1);
            check("dsack", cpu_dsack_n, 2'b10);
            check("berr_quiet", cpu_berr_n, 1);
          end else begin
            check("vector_oe_off", vector_oe, 0);
            check("dsack_off", cpu_dsack_n, 2'b11);
          end
        end
      end
      if (!prev_iack && vme_iack_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_release: got release, required none");
        end else begin
          e = exp_q.pop_front();
          check("rel_kind", K_REL, e.kind);
          check("rel_level", vme_level, e.lvl);
          if (e.lat >= 0) check("rel_latency", cyc - ds_cyc, e.lat);
          check("rel_strobes", {vme_iack_n, vme_as_n, vme_ds0_n}, 3'b111);
          check("rel_terms", {cpu_dsack_n, cpu_berr_n, cpu_avec_n, vector_oe}, 5'b11110);
        end
      end
    end
    prev_term = term;
    prev_iack = vme_iack_n;
    prev_ds   = vme_ds0_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit started;
    reset_n     = 1'b0;
    iack_req    = 1'b0;
    cpu_as      = 1'b1;
    cpu_level   = 3'd0;
    vme_dtack_n = 1'b1;
    vme_berr_n  = 1'b1;
    vme_data    = 8'h00;
    repeat (3) tick();
    check("rst_strobes", {vme_iack_n, vme_as_n, vme_ds0_n}, 3'b111);
    check("rst_terms", {cpu_dsack_n, cpu_berr_n, cpu_avec_n}, 4'b1111);
    check("rst_level", vme_level, 3'b000);
    check("rst_vector", vector, 8'h00);
    check("rst_vector_oe", vector_oe, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Level 5, DTACK four clocks after DS, iack_req dropped mid-cycle.
    push(K_ACK, 3'd5, 8'h40, 7);
    push(K_REL, 3'd5, 8'h00, -1);
    start_cycle(3'd5);
    wait_ds(ok);
    iack_req = 1'b0;
    repeat (4) tick();
    vme_data    = 8'h40;
    vme_dtack_n = 1'b0;
    repeat (6) tick();
    cpu_as = 1'b1;
    repeat (2) tick();
    vme_dtack_n = 1'b1;
    repeat (6) tick();

    // Level 3, no response: timeout on the 16th clock after DS.
    push(K_TO, 3'd3, 8'h00, 16);
    push(K_REL, 3'd3, 8'h00, -1);
    start_cycle(3'd3);
    wait_ds(ok);
    repeat (20) tick();
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    repeat (6) tick();

    // Level 2, DTACK and BERR together: acknowledge wins.
    push(K_ACK, 3'd2, 8'hA5, 5);
    push(K_REL, 3'd2, 8'h00, -1);
    start_cycle(3'd2);
    wait_ds(ok);
    repeat (2) tick();
    vme_data    = 8'hA5;
    vme_dtack_n = 1'b0;
    vme_berr_n  = 1'b0;
    repeat (5) tick();
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    repeat (2) tick();
    vme_dtack_n = 1'b1;
    vme_berr_n  = 1'b1;
    repeat (6) tick();

    // Level 1, VME bus error.
    push(K_BERR, 3'd1, 8'h00, 4);
    push(K_REL, 3'd1, 8'h00, -1);
    start_cycle(3'd1);
    wait_ds(ok);
    tick();
    vme_berr_n = 1'b0;
    repeat (4) tick();
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    tick();
    vme_berr_n = 1'b1;
    repeat (6) tick();

    // Level 4, CPU abandons the cycle during WAIT: release only, no termination.
    push(K_REL, 3'd4, 8'h00, 3);
    start_cycle(3'd4);
    wait_ds(ok);
    repeat (2) tick();
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    repeat (6) tick();

    // Level 7, DTACK held after release: a new request must be ignored.
    push(K_ACK, 3'd7, 8'h3C, 4);
    push(K_REL, 3'd7, 8'h00, -1);
    start_cycle(3'd7);
    wait_ds(ok);
    tick();
    vme_data    = 8'h3C;
    vme_dtack_n = 1'b0;
    repeat (6) tick();
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    repeat (3) tick();
    iack_req = 1'b1;
    cpu_as   = 1'b0;
    started  = 1'b0;
    repeat (6) begin
      tick();
      if (vme_iack_n === 1'b0) started = 1'b1;
    end
    check("release_holds", started, 0);
    cpu_as      = 1'b1;
    iack_req    = 1'b0;
    vme_dtack_n = 1'b1;
    repeat (6) tick();

    // Level 6, reset asserted during WAIT: strobes negate without a clock edge.
    start_cycle(3'd6);
    wait_ds(ok);
    tick();
    reset_n = 1'b0;
    #2;
    check("async_rst_strobes", {vme_iack_n, vme_as_n, vme_ds0_n}, 3'b111);
    check("async_rst_level", vme_level, 3'b000);
    check("async_rst_vector", vector, 8'h00);
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Level 0 after reset recovery.
    push(K_ACK, 3'd0, 8'hFF, 4);
    push(K_REL, 3'd0, 8'h00, -1);
    start_cycle(3'd0);
    wait_ds(ok);
    tick();
    vme_data    = 8'hFF;
    vme_dtack_n = 1'b0;
    repeat (5) tick();
    cpu_as   = 1'b1;
    iack_req = 1'b0;
    tick();
    vme_dtack_n = 1'b1;
    repeat (6) tick();

    check("queue_drained", exp_q.size(), 0);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_event: kind %0d never seen, required level %0d", e.kind, e.lvl);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
